uart_rx_oversample: RTL and testbench



---
 rtl/uart_rx_oversample.sv | 154 +++++++++++++++
 tb/tb_uart_rx_oversample.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 16x-oversampled UART receiver: start/data/stop framing on a shared baud tick.
// Optional even-parity check enabled with `define UART_RX_PARITY_EN.
module uart_rx_oversample #(
   parameter int unsigned dataBits = 8,
   parameter int unsigned sbTick   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sTick,
   input  logic                rx,
   output logic [dataBits-1:0] dout,
   output logic                rxDoneTick,
`ifdef UART_RX_PARITY_EN
   output logic                parityErr,
`endif
   output logic                frameErr
);

   localparam int unsigned sW = (sbTick > 16) ? 5 : 4;

   typedef enum logic [2:0] {
      stIdle,
      stStart,
      stData,
`ifdef UART_RX_PARITY_EN
      stParity,
`endif
      stStop
   } stateType;

   stateType            state;
   logic [sW-1:0]       s;
   logic [2:0]          n;
   logic [dataBits-1:0] b;
   logic                rxMeta;
   logic                rxS;
`ifdef UART_RX_PARITY_EN
   logic                parityBad;
`endif

   // rx is asynchronous to clk; flops reset to the idle (high) level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rxMeta <= 1'b1;
         rxS    <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxS    <= rxMeta;
      end
   end

   // Framing FSM; pulses default low and are raised only on the terminating tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= stIdle;
         s          <= '0;
         n          <= '0;
         b          <= '0;
         dout       <= '0;
         rxDoneTick <= 1'b0;
         frameErr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr  <= 1'b0;
         parityBad  <= 1'b0;
`endif
      end else begin
         rxDoneTick <= 1'b0;
         frameErr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErr  <= 1'b0;
`endif
         case (state)
            stIdle: begin
               if (!rxS) begin
                  state <= stStart;
                  s     <= '0;
               end
            end
            stStart: begin
               if (sTick) begin
                  if (s == sW'(7)) begin
                     if (!rxS) begin
                        state <= stData;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= stIdle;
                        s     <= '0;
                     end
                  end else begin
                     s <= s + sW'(1);
                  end
               end
            end
            stData: begin
               if (sTick) begin
                  if (s == sW'(15)) begin
                     s <= '0;
                     b <= {rxS, b[dataBits-1:1]};
                     if (n == 3'(dataBits - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state <= stParity;
`else
                        state <= stStop;
`endif
                     end else begin
                        n <= n + 3'd1;
                     end
                  end else begin
                     s <= s + sW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            stParity: begin
               if (sTick) begin
                  if (s == sW'(15)) begin
                     s         <= '0;
                     parityBad <= (^b) ^ rxS;
                     state     <= stStop;
                  end else begin
                     s <= s + sW'(1);
                  end
               end
            end
`endif
            stStop: begin
               if (sTick) begin
                  if (s == sW'(sbTick - 1)) begin
                     if (rxS) begin
                        dout       <= b;
                        rxDoneTick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parityErr  <= parityBad;
`endif
                     end else begin
                        frameErr <= 1'b1;
                     end
                     state <= stIdle;
                     s     <= '0;
                  end else begin
                     s <= s + sW'(1);
                  end
               end
            end
            default: begin
               state <= stIdle;
               s     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frame-level expectation queue plus literal pins.
// Parity frames are sent and checked when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversample;

   localparam int bitClk = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sTick = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dout;
   logic       rxDoneTick;
   logic       frameErr;
   logic       parityErr;

   typedef struct {
      logic       good;
      logic [7:0] data;
      logic       par;
   } expType;

   expType     expQ[$];
   logic [7:0] modelDout = 8'h00;
   logic       prevPulse = 1'b0;
   int         checks = 0;
   int         errors = 0;
   int         doneCount = 0;
   int         ferrCount = 0;
   int         perrCount = 0;
   int         tickCnt = 0;

   uart_rx_oversample #(.dataBits(8), .sbTick(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .sTick      (sTick),
      .rx         (rx),
      .dout       (dout),
      .rxDoneTick (rxDoneTick),
`ifdef UART_RX_PARITY_EN
      .parityErr  (parityErr),
`endif
      .frameErr   (frameErr)
   );

`ifndef UART_RX_PARITY_EN
   assign parityErr = 1'b0;
`endif

   always #5 clk = ~clk;

   // one-cycle baud tick every 4 clocks
   always begin
      @(posedge clk);
      #1;
      sTick = (tickCnt == 3);
      tickCnt = (tickCnt + 1) % 4;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic waitClk(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Every cycle: pulses must match the queued frame outcome, dout must track the model
   always @(negedge clk) begin
      expType e;
      if (reset) begin
         check("resetDout", 32'(dout), 32'h0);
         check("resetDone", 32'(rxDoneTick), 32'h0);
         check("resetFerr", 32'(frameErr), 32'h0);
         check("resetPerr", 32'(parityErr), 32'h0);
         modelDout = 8'h00;
         prevPulse = 1'b0;
         expQ.delete();
      end else begin
         check("exclusive", 32'(rxDoneTick & frameErr), 32'h0);
         check("pulseWidth", 32'(prevPulse & (rxDoneTick | frameErr)), 32'h0);
         if (rxDoneTick || frameErr) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedPulse: done=%0b ferr=%0b with no frame pending at %0t",
                        rxDoneTick, frameErr, $time);
            end else begin
               e = expQ.pop_front();
               check("pulseKind", 32'(rxDoneTick), 32'(e.good));
               if (e.good) modelDout = e.data;
               check("parityErr", 32'(parityErr), 32'(e.good & e.par));
            end
         end else begin
            check("parityIdle", 32'(parityErr), 32'h0);
         end
         check("dout", 32'(dout), 32'(modelDout));
         if (rxDoneTick) doneCount++;
         if (frameErr) ferrCount++;
         if (parityErr) perrCount++;
         prevPulse = rxDoneTick | frameErr;
      end
   end

   // par is the transmitted parity bit; stopLen shortens a low stop bit
   task automatic sendFrame(input logic [7:0] d, input logic par, input logic stopVal,
                            input int stopLen);
      expType e;
      e.good = stopVal;
      e.data = d;
`ifdef UART_RX_PARITY_EN
      e.par = (^d) ^ par;
`else
      e.par = 1'b0;
`endif
      expQ.push_back(e);
      rx = 1'b0;
      waitClk(bitClk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         waitClk(bitClk);
      end
`ifdef UART_RX_PARITY_EN
      rx = par;
      waitClk(bitClk);
`endif
      rx = stopVal;
      waitClk(stopLen);
      rx = 1'b1;
      waitClk(bitClk - stopLen);
      check("frameDrained", 32'(expQ.size()), 32'h0);
   endtask

   task automatic sendGood(input logic [7:0] d);
      sendFrame(d, ^d, 1'b1, bitClk);
   endtask

   initial begin
      logic [7:0] aborted;
      reset = 1'b1;
      rx = 1'b1;
      waitClk(3);
      reset = 1'b0;
      waitClk(20);

      // 1: plain 0xA5
      sendGood(8'hA5);
      waitClk(bitClk);
      check("t1Done", 32'(doneCount), 32'd1);
      check("t1Ferr", 32'(ferrCount), 32'd0);
      check("t1Dout", 32'(dout), 32'hA5);

      // 2: short low glitch of 5 ticks
      rx = 1'b0;
      waitClk(20);
      rx = 1'b1;
      waitClk(3 * bitClk);
      check("t2Done", 32'(doneCount), 32'd1);
      check("t2Ferr", 32'(ferrCount), 32'd0);
      check("t2Dout", 32'(dout), 32'hA5);

      // 3: 0x3C with a low stop bit
      sendFrame(8'h3C, ^8'h3C, 1'b0, 40);
      waitClk(2 * bitClk);
      check("t3Done", 32'(doneCount), 32'd1);
      check("t3Ferr", 32'(ferrCount), 32'd1);
      check("t3Dout", 32'(dout), 32'hA5);

      // 4: back-to-back 0x00 then 0xFF
      sendGood(8'h00);
      check("t4First", 32'(dout), 32'h00);
      sendGood(8'hFF);
      waitClk(bitClk);
      check("t4Done", 32'(doneCount), 32'd3);
      check("t4Dout", 32'(dout), 32'hFF);

      // 5: reset during data bit 4 of 0x81, then 0x5A
      aborted = 8'h81;
      rx = 1'b0;
      waitClk(bitClk);
      for (int i = 0; i < 4; i++) begin
         rx = aborted[i];
         waitClk(bitClk);
      end
      rx = aborted[4];
      waitClk(30);
      reset = 1'b1;
      waitClk(3);
      check("t5ResetDout", 32'(dout), 32'h0);
      reset = 1'b0;
      rx = 1'b1;
      waitClk(2 * bitClk);
      check("t5NoPulse", 32'(doneCount), 32'd3);
      sendGood(8'h5A);
      waitClk(bitClk);
      check("t5Done", 32'(doneCount), 32'd4);
      check("t5Dout", 32'(dout), 32'h5A);

`ifdef UART_RX_PARITY_EN
      // 6: 0x07 has odd weight, so parity bit 0 is a mismatch
      sendFrame(8'h07, 1'b0, 1'b1, bitClk);
      check("t6Perr", 32'(perrCount), 32'd1);
      sendFrame(8'h07, 1'b1, 1'b1, bitClk);
      waitClk(bitClk);
      check("t6PerrClean", 32'(perrCount), 32'd1);
      check("t6Dout", 32'(dout), 32'h07);
`endif

      check("finalFerr", 32'(ferrCount), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
               checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
